// File: rtl/cpu_control.sv
// Mini-CPU sequencer and ALU: captures an instruction on a send press, computes the
// result from memory read data, and handshakes the write-back with the memory bank.
module cpu_control #(
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              power,
    input  logic              send,
    input  logic [17:0]       instr,
    input  logic              stored,
    input  logic [DATA_W-1:0] v1RAM,
    input  logic [DATA_W-1:0] v2RAM,
    output logic [2:0]        stateCPU,
    output logic [2:0]        opcode,
    output logic [3:0]        addr1,
    output logic [3:0]        addr2,
    output logic [3:0]        addr3,
    output logic [DATA_W-1:0] valorGuardarRAM,
    output logic [DATA_W-1:0] disp_value,
    output logic              disp_valid,
    output logic              busy,
    output logic              err_timeout
);

    typedef enum logic [2:0] {
        S_OFF    = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_CALC   = 3'd3,
        S_DS     = 3'd4
    } state_t;

    localparam logic [2:0] OP_LOAD    = 3'd0;
    localparam logic [2:0] OP_ADD     = 3'd1;
    localparam logic [2:0] OP_ADDI    = 3'd2;
    localparam logic [2:0] OP_SUB     = 3'd3;
    localparam logic [2:0] OP_SUBI    = 3'd4;
    localparam logic [2:0] OP_MUL     = 3'd5;
    localparam logic [2:0] OP_CLEAR   = 3'd6;
    localparam logic [2:0] OP_DISPLAY = 3'd7;

    localparam int              CW    = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]   TLAST = CW'(TIMEOUT - 1);

    state_t            state;
    logic              send_q;
    logic [6:0]        imm7;
    logic [CW-1:0]     tcnt;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] result;

    assign stateCPU = state;
    assign imm      = {{(DATA_W-7){imm7[6]}}, imm7};

    // Low half of a two's-complement product is sign-agnostic, so a plain multiply suffices.
    always_comb begin
        result = '0;
        case (opcode)
            OP_LOAD:    result = imm;
            OP_ADD:     result = v1RAM + v2RAM;
            OP_ADDI:    result = v1RAM + imm;
            OP_SUB:     result = v1RAM - v2RAM;
            OP_SUBI:    result = v1RAM - imm;
            OP_MUL:     result = v1RAM * imm;
            OP_CLEAR:   result = '0;
            OP_DISPLAY: result = v1RAM;
            default:    result = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state           <= S_OFF;
            send_q          <= 1'b0;
            opcode          <= '0;
            addr1           <= '0;
            addr2           <= '0;
            addr3           <= '0;
            imm7            <= '0;
            tcnt            <= '0;
            valorGuardarRAM <= '0;
            disp_value      <= '0;
            disp_valid      <= 1'b0;
            busy            <= 1'b0;
            err_timeout     <= 1'b0;
        end else begin
            send_q <= send;
            if (!power) begin
                state      <= S_OFF;
                busy       <= 1'b0;
                disp_valid <= 1'b0;
                tcnt       <= '0;
            end else begin
                case (state)
                    S_OFF: begin
                        state <= S_FETCH;
                        busy  <= 1'b0;
                    end
                    S_FETCH: begin
                        if (send && !send_q) begin
                            opcode <= instr[17:15];
                            addr1  <= instr[14:11];
                            addr2  <= instr[10:7];
                            addr3  <= instr[6:3];
                            imm7   <= instr[6:0];
                            if (instr[17:15] != OP_DISPLAY)
                                disp_valid <= 1'b0;
                            state  <= S_DECODE;
                            busy   <= 1'b1;
                        end
                    end
                    S_DECODE: state <= S_CALC;
                    S_CALC: begin
                        valorGuardarRAM <= result;
                        tcnt            <= '0;
                        state           <= S_DS;
                    end
                    S_DS: begin
                        // stored is checked before the limit so a last-cycle ack still succeeds
                        if (opcode == OP_DISPLAY) begin
                            disp_value <= valorGuardarRAM;
                            disp_valid <= 1'b1;
                            tcnt       <= '0;
                            state      <= S_FETCH;
                            busy       <= 1'b0;
                        end else if (stored) begin
                            tcnt  <= '0;
                            state <= S_FETCH;
                            busy  <= 1'b0;
                        end else if (tcnt == TLAST) begin
                            err_timeout <= 1'b1;
                            tcnt        <= '0;
                            state       <= S_FETCH;
                            busy        <= 1'b0;
                        end else begin
                            tcnt <= tcnt + 1'b1;
                        end
                    end
                    default: begin
                        state <= S_OFF;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cpu_control.sv
// Directed bench for cpu_control: sequencing, ALU results, display path, edge
// detection, stored timeout, power-off and reset abort.
module tb_cpu_control;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        power;
    logic        send;
    logic [17:0] instr;
    logic        stored;
    logic [15:0] v1RAM;
    logic [15:0] v2RAM;
    logic [2:0]  stateCPU;
    logic [2:0]  opcode;
    logic [3:0]  addr1, addr2, addr3;
    logic [15:0] valorGuardarRAM;
    logic [15:0] disp_value;
    logic        disp_valid;
    logic        busy;
    logic        err_timeout;

    int nvec = 0;
    int nerr = 0;

    cpu_control #(.DATA_W(16), .TIMEOUT(8)) dut (
        .clk(clk), .rst_n(rst_n), .power(power), .send(send), .instr(instr),
        .stored(stored), .v1RAM(v1RAM), .v2RAM(v2RAM), .stateCPU(stateCPU),
        .opcode(opcode), .addr1(addr1), .addr2(addr2), .addr3(addr3),
        .valorGuardarRAM(valorGuardarRAM), .disp_value(disp_value),
        .disp_valid(disp_valid), .busy(busy), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One-cycle send pulse; the edge is sampled on the tick inside.
    task automatic press(input logic [17:0] ins);
        instr = ins;
        send  = 1'b1;
        tick();
        send  = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; power = 1'b1; send = 1'b0; stored = 1'b0;
        instr = '0; v1RAM = '0; v2RAM = '0;
        tick(); tick();
        nvec++;
        if (stateCPU !== 3'd0) begin nerr++; $display("FAIL reset_state: got %0d want 0", stateCPU); end
        nvec++;
        if ({opcode, addr1, addr2, addr3, valorGuardarRAM, disp_value, disp_valid, busy, err_timeout} !== '0) begin
            nerr++;
            $display("FAIL reset_outputs: op=%0d a1=%0d a2=%0d a3=%0d val=%h disp=%h dv=%b busy=%b err=%b want all 0",
                     opcode, addr1, addr2, addr3, valorGuardarRAM, disp_value, disp_valid, busy, err_timeout);
        end
        rst_n = 1'b1;
        tick();
        nvec++;
        if (stateCPU !== 3'd1) begin nerr++; $display("FAIL reset_to_fetch: got %0d want 1", stateCPU); end
    endtask

    task automatic test_load_timing();
        v1RAM = 16'h0000; v2RAM = 16'h0000;
        press({3'd0, 4'd3, 4'd0, 7'b0000101});
        nvec++;
        if (stateCPU !== 3'd2 || busy !== 1'b1) begin nerr++; $display("FAIL load_decode: state=%0d busy=%b want 2/1", stateCPU, busy); end
        nvec++;
        if (opcode !== 3'd0 || addr1 !== 4'd3 || addr3 !== 4'd0) begin
            nerr++; $display("FAIL load_fields: op=%0d a1=%0d a3=%0d want 0/3/0", opcode, addr1, addr3);
        end
        tick();
        nvec++;
        if (stateCPU !== 3'd3) begin nerr++; $display("FAIL load_calc: got %0d want 3", stateCPU); end
        tick();
        nvec++;
        if (stateCPU !== 3'd4 || valorGuardarRAM !== 16'h0005) begin
            nerr++; $display("FAIL load_store: state=%0d val=%h want 4/0005", stateCPU, valorGuardarRAM);
        end
        tick();
        nvec++;
        if (stateCPU !== 3'd4) begin nerr++; $display("FAIL load_wait_stored: got %0d want 4", stateCPU); end
        stored = 1'b1;
        tick();
        stored = 1'b0;
        nvec++;
        if (stateCPU !== 3'd1 || busy !== 1'b0) begin nerr++; $display("FAIL load_done: state=%0d busy=%b want 1/0", stateCPU, busy); end
    endtask

    task automatic test_alu();
        logic [17:0] ins [7];
        logic [15:0] a   [7];
        logic [15:0] b   [7];
        logic [15:0] exp [7];
        ins[0] = {3'd0, 4'd1, 4'd0, 7'h05}; a[0] = 16'hAAAA; b[0] = 16'h0000; exp[0] = 16'h0005; // LOAD
        ins[1] = {3'd1, 4'd1, 4'd2, 7'h00}; a[1] = 16'h7FFF; b[1] = 16'h0001; exp[1] = 16'h8000; // ADD
        ins[2] = {3'd4, 4'd1, 4'd0, 7'h7F}; a[2] = 16'h0000; b[2] = 16'h0000; exp[2] = 16'h0001; // SUBI -1
        ins[3] = {3'd5, 4'd1, 4'd0, 7'h20}; a[3] = 16'h0100; b[3] = 16'h0000; exp[3] = 16'h2000; // MUL +32
        ins[4] = {3'd5, 4'd1, 4'd0, 7'h40}; a[4] = 16'h0100; b[4] = 16'h0000; exp[4] = 16'hC000; // MUL -64
        ins[5] = {3'd3, 4'd1, 4'd2, 7'h00}; a[5] = 16'h0000; b[5] = 16'h0001; exp[5] = 16'hFFFF; // SUB
        ins[6] = {3'd2, 4'd1, 4'd0, 7'h7E}; a[6] = 16'h0010; b[6] = 16'h0000; exp[6] = 16'h000E; // ADDI -2
        for (int i = 0; i < 7; i++) begin
            v1RAM = a[i]; v2RAM = b[i];
            press(ins[i]);
            tick(); tick();
            nvec++;
            if (stateCPU !== 3'd4 || valorGuardarRAM !== exp[i]) begin
                nerr++; $display("FAIL alu_%0d: state=%0d val=%h want 4/%h", i, stateCPU, valorGuardarRAM, exp[i]);
            end
            stored = 1'b1;
            tick();
            stored = 1'b0;
        end
        v1RAM = 16'h1234;
        press({3'd6, 4'd1, 4'd0, 7'h00});
        tick(); tick();
        nvec++;
        if (valorGuardarRAM !== 16'h0000) begin nerr++; $display("FAIL alu_clear: got %h want 0000", valorGuardarRAM); end
        stored = 1'b1;
        tick();
        stored = 1'b0;
    endtask

    task automatic test_display();
        v1RAM = 16'h1234;
        press({3'd7, 4'd5, 4'd0, 7'h00});
        tick(); tick();
        nvec++;
        if (stateCPU !== 3'd4 || disp_valid !== 1'b0 || valorGuardarRAM !== 16'h1234) begin
            nerr++; $display("FAIL disp_pre: state=%0d dv=%b val=%h want 4/0/1234", stateCPU, disp_valid, valorGuardarRAM);
        end
        tick();
        nvec++;
        if (stateCPU !== 3'd1 || disp_valid !== 1'b1 || disp_value !== 16'h1234) begin
            nerr++; $display("FAIL disp_post: state=%0d dv=%b disp=%h want 1/1/1234", stateCPU, disp_valid, disp_value);
        end
        press({3'd0, 4'd2, 4'd0, 7'h01});
        nvec++;
        if (disp_valid !== 1'b0 || disp_value !== 16'h1234) begin
            nerr++; $display("FAIL disp_clear_on_load: dv=%b disp=%h want 0/1234", disp_valid, disp_value);
        end
        tick(); tick();
        stored = 1'b1;
        tick();
        stored = 1'b0;
    endtask

    task automatic test_back_to_back();
        int decodes;
        decodes = 0;
        v1RAM = 16'h0000;
        instr  = {3'd0, 4'd4, 4'd0, 7'h09};
        stored = 1'b1;
        send   = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (stateCPU == 3'd2) decodes++;
        end
        send   = 1'b0;
        stored = 1'b0;
        tick();
        nvec++;
        if (decodes != 1 || stateCPU !== 3'd1) begin
            nerr++; $display("FAIL send_held: decodes=%0d state=%0d want 1/1", decodes, stateCPU);
        end
        press({3'd0, 4'd4, 4'd0, 7'h09});
        tick();
        send = 1'b1;
        tick();
        send = 1'b0;
        tick();
        stored = 1'b1;
        tick();
        stored = 1'b0;
        tick(); tick();
        nvec++;
        if (stateCPU !== 3'd1 || busy !== 1'b0) begin
            nerr++; $display("FAIL busy_press_ignored: state=%0d busy=%b want 1/0", stateCPU, busy);
        end
    endtask

    task automatic test_timeout();
        // Ack on the very cycle the limit is reached counts as success.
        press({3'd0, 4'd6, 4'd0, 7'h03});
        tick(); tick();
        for (int i = 0; i < 7; i++) tick();
        nvec++;
        if (stateCPU !== 3'd4 || err_timeout !== 1'b0) begin
            nerr++; $display("FAIL timeout_edge_wait: state=%0d err=%b want 4/0", stateCPU, err_timeout);
        end
        stored = 1'b1;
        tick();
        stored = 1'b0;
        nvec++;
        if (stateCPU !== 3'd1 || err_timeout !== 1'b0) begin
            nerr++; $display("FAIL timeout_edge_ack: state=%0d err=%b want 1/0", stateCPU, err_timeout);
        end
        press({3'd0, 4'd6, 4'd0, 7'h03});
        tick(); tick();
        for (int i = 0; i < 7; i++) tick();
        nvec++;
        if (stateCPU !== 3'd4 || err_timeout !== 1'b0) begin
            nerr++; $display("FAIL timeout_wait: state=%0d err=%b want 4/0", stateCPU, err_timeout);
        end
        tick();
        nvec++;
        if (stateCPU !== 3'd1 || err_timeout !== 1'b1) begin
            nerr++; $display("FAIL timeout_abort: state=%0d err=%b want 1/1", stateCPU, err_timeout);
        end
    endtask

    task automatic test_power_off();
        press({3'd0, 4'd7, 4'd0, 7'h02});
        tick();
        nvec++;
        if (stateCPU !== 3'd3) begin nerr++; $display("FAIL power_calc: got %0d want 3", stateCPU); end
        power = 1'b0;
        tick();
        nvec++;
        if (stateCPU !== 3'd0 || busy !== 1'b0 || err_timeout !== 1'b1 || disp_value !== 16'h1234) begin
            nerr++; $display("FAIL power_off: state=%0d busy=%b err=%b disp=%h want 0/0/1/1234",
                             stateCPU, busy, err_timeout, disp_value);
        end
        power = 1'b1;
        tick();
        nvec++;
        if (stateCPU !== 3'd1) begin nerr++; $display("FAIL power_on: got %0d want 1", stateCPU); end
    endtask

    task automatic test_reset_mid();
        press({3'd0, 4'd8, 4'd0, 7'h04});
        tick();
        rst_n = 1'b0;
        tick();
        nvec++;
        if (stateCPU !== 3'd0 || err_timeout !== 1'b0 || disp_value !== 16'h0000 || valorGuardarRAM !== 16'h0000) begin
            nerr++; $display("FAIL reset_mid: state=%0d err=%b disp=%h val=%h want 0/0/0000/0000",
                             stateCPU, err_timeout, disp_value, valorGuardarRAM);
        end
        rst_n = 1'b1;
        tick(); tick();
        nvec++;
        if (stateCPU !== 3'd1 || valorGuardarRAM !== 16'h0000) begin
            nerr++; $display("FAIL reset_mid_resume: state=%0d val=%h want 1/0000", stateCPU, valorGuardarRAM);
        end
    endtask

    initial begin
        test_reset();
        test_load_timing();
        test_alu();
        test_display();
        test_back_to_back();
        test_timeout();
        test_power_off();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

endmodule
